ram_io_responder: RTL

RAM_IO_RESPONDER -- requirements
Module: ram_io_responder

---
 rtl/ram_io_responder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ram_io_responder.sv
// ram_io_responder: byte RAM plus memory-mapped UART RX/TX, cycle counter
// and stop flag behind a single CPU access port. Reads return one cycle later.
module ram_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_DEPTH       = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        program_done,
  output logic        tx_overflow
);

  localparam int PW       = $clog2(TX_DEPTH);
  localparam int RAM_SIZE = 1 << RAM_ADDR_WIDTH;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(TX_DEPTH);
  localparam logic [PW:0] THR_C   = (PW+1)'(TX_DEPTH - 1);

  logic [7:0] ram [RAM_SIZE];
  logic [7:0] ram_rd_q;
  logic [7:0] fifo_q [TX_DEPTH];

  logic [7:0]    io_rd_q, io_rd_d;
  logic          sel_io_q, sel_io_d;
  logic          rx_pop_q, rx_pop_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   snap_q, snap_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          full_q, full_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  logic                      is_io, io_off0, io_off4, io_cnt_rng;
  logic                      rd_acc, wr_acc, push, push_ok, pop;
  logic [7:0]                push_data;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic                      unused_addr;

  assign unused_addr = ^mem_a[31:18];
  assign ram_idx     = mem_a[RAM_ADDR_WIDTH-1:0];

  // Address decode, IO read mux, FIFO bookkeeping and next-state values
  always_comb begin
    is_io      = (mem_a[17:16] == 2'b11);
    io_off0    = is_io && (mem_a[15:0] == 16'h0000);
    io_off4    = is_io && (mem_a[15:0] == 16'h0004);
    io_cnt_rng = is_io && (mem_a[15:2] == 14'h0001);
    rd_acc     = rdy_in && !mem_wr;
    wr_acc     = rdy_in && mem_wr;

    // The stop write enqueues a 0x00 so the host sees an end marker.
    push      = wr_acc && ((io_off0 && (mem_dout != 8'h00)) || io_off4);
    push_data = io_off4 ? 8'h00 : mem_dout;
    pop       = (count_q != '0) && tx_ready;
    push_ok   = push && ((count_q != DEPTH_C) || pop);

    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    full_d   = (count_d >= THR_C);
    ovf_d    = ovf_q || (push && !push_ok);
    done_d   = done_q || (wr_acc && io_off4);

    cnt_d  = rdy_in ? cnt_q + 32'd1 : cnt_q;
    snap_d = (rd_acc && io_off4) ? cnt_q : snap_q;

    sel_io_d = sel_io_q;
    io_rd_d  = io_rd_q;
    if (rd_acc) begin
      sel_io_d = is_io;
      io_rd_d  = 8'h00;
      if (io_off0 && rx_valid) begin
        io_rd_d = rx_data;
      end else if (io_cnt_rng) begin
        // Offset 4 returns the live count it is snapshotting; 5..7 use the snapshot.
        case (mem_a[1:0])
          2'd0:    io_rd_d = cnt_q[7:0];
          2'd1:    io_rd_d = snap_q[15:8];
          2'd2:    io_rd_d = snap_q[23:16];
          default: io_rd_d = snap_q[31:24];
        endcase
      end
    end
    rx_pop_d = rd_acc && io_off0 && rx_valid;
  end

  // Byte RAM: write-through in the presented cycle, read data held until next RAM read
  always_ff @(posedge clk_in) begin
    if (wr_acc && !is_io) ram[ram_idx] <= mem_dout;
    if (rd_acc && !is_io) ram_rd_q <= ram[ram_idx];
  end

  // TX FIFO storage, no reset needed since occupancy gates visibility
  always_ff @(posedge clk_in) begin
    if (push_ok) fifo_q[wr_ptr_q] <= push_data;
  end

  // Control state with synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      io_rd_q  <= 8'h00;
      sel_io_q <= 1'b1;
      rx_pop_q <= 1'b0;
      cnt_q    <= 32'd0;
      snap_q   <= 32'd0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      full_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      io_rd_q  <= io_rd_d;
      sel_io_q <= sel_io_d;
      rx_pop_q <= rx_pop_d;
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign mem_din        = sel_io_q ? io_rd_q : ram_rd_q;
  assign rx_pop         = rx_pop_q;
  assign tx_valid       = (count_q != '0);
  assign tx_data        = fifo_q[rd_ptr_q];
  assign io_buffer_full = full_q;
  assign program_done   = done_q;
  assign tx_overflow    = ovf_q;

endmodule
